// File: rtl/maxnet_ctrl.sv
// Maxnet sequencing controller: loads neuron inputs, iterates MAC/activation
// updates and reports a sole winner, an all-zero result or a timeout.
module maxnet_ctrl #(
    parameter int N        = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_ITER = 15,
    parameter int ITER_W   = 4,
    parameter int SETTLE   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [5*N-1:0]     act_out,
    output logic               ld_init,
    output logic               ld_reg,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   winner,
    output logic               found,
    output logic               all_zero,
    output logic               timeout,
    output logic [ITER_W-1:0]  iter_cnt
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_COMPUTE, S_UPDATE, S_CHECK, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [1:0]          pos_cnt_q, pos_cnt_d, pos_cnt_c;
    logic [IDX_W-1:0]    pos_idx_q, pos_idx_d, pos_idx_c;
    logic [IDX_W-1:0]    winner_q, winner_d;
    logic                found_q, found_d;
    logic                zero_q, zero_d;
    logic                tmo_q, tmo_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            settle_q  <= '0;
            iter_q    <= '0;
            pos_cnt_q <= '0;
            pos_idx_q <= '0;
            winner_q  <= '0;
            found_q   <= 1'b0;
            zero_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            iter_q    <= iter_d;
            pos_cnt_q <= pos_cnt_d;
            pos_idx_q <= pos_idx_d;
            winner_q  <= winner_d;
            found_q   <= found_d;
            zero_q    <= zero_d;
            tmo_q     <= tmo_d;
        end
    end

    // Positive = sign clear and non-zero magnitude; count saturates at 2.
    always_comb begin
        pos_cnt_c = 2'd0;
        pos_idx_c = '0;
        for (int i = 0; i < N; i++) begin
            if (!act_out[5*i+4] && act_out[5*i +: 4] != 4'd0) begin
                if (pos_cnt_c == 2'd0) pos_idx_c = IDX_W'(i);
                if (pos_cnt_c != 2'd2) pos_cnt_c = pos_cnt_c + 2'd1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: begin
                state_d  = S_COMPUTE;
                settle_d = '0;
            end
            S_COMPUTE: begin
                if (settle_q == SW'(SETTLE - 1)) state_d = S_UPDATE;
                else settle_d = settle_q + SW'(1);
            end
            S_UPDATE: state_d = S_CHECK;
            S_CHECK: begin
                if (pos_cnt_q != 2'd2 || iter_q == ITER_W'(MAX_ITER)) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_COMPUTE;
                    settle_d = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        iter_d    = iter_q;
        pos_cnt_d = pos_cnt_q;
        pos_idx_d = pos_idx_q;
        winner_d  = winner_q;
        found_d   = found_q;
        zero_d    = zero_q;
        tmo_d     = tmo_q;
        if (state_q == S_IDLE && start) begin
            iter_d  = '0;
            found_d = 1'b0;
            zero_d  = 1'b0;
            tmo_d   = 1'b0;
        end
        if (state_q == S_UPDATE) begin
            iter_d    = iter_q + ITER_W'(1);
            pos_cnt_d = pos_cnt_c;
            pos_idx_d = pos_idx_c;
        end
        if (state_q == S_CHECK) begin
            if (pos_cnt_q == 2'd1) begin
                found_d  = 1'b1;
                winner_d = pos_idx_q;
            end else if (pos_cnt_q == 2'd0) begin
                zero_d   = 1'b1;
                winner_d = '0;
            end else if (iter_q == ITER_W'(MAX_ITER)) begin
                tmo_d    = 1'b1;
                winner_d = '0;
            end
        end
    end

    always_comb begin
        busy    = 1'b0;
        ld_init = 1'b0;
        ld_reg  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                busy    = 1'b1;
                ld_init = 1'b1;
            end
            S_COMPUTE: busy = 1'b1;
            S_UPDATE: begin
                busy   = 1'b1;
                ld_reg = 1'b1;
            end
            S_CHECK: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign winner   = winner_q;
    assign found    = found_q;
    assign all_zero = zero_q;
    assign timeout  = tmo_q;
    assign iter_cnt = iter_q;

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Self-checking bench for maxnet_ctrl: directed scenarios plus randomized
// runs compared against a run-level model of the iteration rules.
module tb_maxnet_ctrl;

    localparam int N        = 4;
    localparam int IDX_W    = 2;
    localparam int MAX_ITER = 15;
    localparam int ITER_W   = 4;
    localparam int SETTLE   = 1;
    localparam int W        = 5 * N;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [W-1:0]      act_out;
    logic              ld_init, ld_reg, busy, done;
    logic [IDX_W-1:0]  winner;
    logic              found, all_zero, timeout;
    logic [ITER_W-1:0] iter_cnt;

    int checks = 0;
    int errors = 0;
    int prev_w = 0;
    logic [W-1:0] vecs [16];
    int nv;

    maxnet_ctrl #(
        .N(N), .IDX_W(IDX_W), .MAX_ITER(MAX_ITER),
        .ITER_W(ITER_W), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .act_out(act_out),
        .ld_init(ld_init), .ld_reg(ld_reg), .busy(busy), .done(done),
        .winner(winner), .found(found), .all_zero(all_zero),
        .timeout(timeout), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int npos(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < N; i++) begin
            logic [4:0] f = v[5*i +: 5];
            if (f[4] == 1'b0 && f[3:0] != 4'd0) n++;
        end
        return n;
    endfunction

    function automatic int lowpos(input logic [W-1:0] v);
        for (int i = 0; i < N; i++) begin
            logic [4:0] f = v[5*i +: 5];
            if (f[4] == 1'b0 && f[3:0] != 4'd0) return i;
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] vec_at(input int j);
        return vecs[(j < nv) ? j : nv - 1];
    endfunction

    function automatic logic [4:0] rnd_field();
        int r = int'($urandom_range(0, 3));
        logic [4:0] f;
        if (r == 0) f = 5'd0;
        else if (r == 1) f = {1'b1, 4'($urandom)};
        else f = {1'b0, 4'($urandom_range(1, 15))};
        return f;
    endfunction

    // One full run: start edge, cycle-by-cycle checks, then the IDLE cycle.
    task automatic do_run(input bit rnd_start, input bit hold);
        int k = 0, ef = 0, ez = 0, et = 0, ew = 0;
        int dc, ldc, p, per;
        bit fin = 0;
        per = SETTLE + 2;
        for (int j = 0; j < MAX_ITER; j++) begin
            if (!fin) begin
                p = npos(vec_at(j));
                if (p <= 1 || j + 1 == MAX_ITER) begin
                    fin = 1;
                    k = j + 1;
                    if (p == 1) begin ef = 1; ew = lowpos(vec_at(j)); end
                    else if (p == 0) ez = 1;
                    else et = 1;
                end
            end
        end
        dc = 5 + (k - 1) * per;
        ldc = 0;
        act_out = vecs[0];
        start = 1'b1;
        tick();
        for (int c = 1; c <= dc; c++) begin
            bit last = (c == dc);
            bit exp_ld = (c >= 3) && ((c - 3) % per == 0) && ((c - 3) / per < k);
            chk("busy", 32'(busy), 32'(!last));
            chk("ld_init", 32'(ld_init), 32'(c == 1));
            chk("ld_reg", 32'(ld_reg), 32'(exp_ld));
            chk("done", 32'(done), 32'(last));
            chk("iter_cnt", 32'(iter_cnt), 32'(ldc));
            chk("found", 32'(found), last ? 32'(ef) : 32'd0);
            chk("all_zero", 32'(all_zero), last ? 32'(ez) : 32'd0);
            chk("timeout", 32'(timeout), last ? 32'(et) : 32'd0);
            chk("winner", 32'(winner), last ? 32'(ew) : 32'(prev_w));
            if (!last) begin
                if (ld_reg) ldc++;
                else act_out = vec_at(ldc);
                start = rnd_start ? 1'($urandom) : hold;
                tick();
            end
        end
        chk("ld_reg_pulses", 32'(ldc), 32'(k));
        prev_w = ew;
        start = hold;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_found", 32'(found), 32'(ef));
        chk("idle_winner", 32'(winner), 32'(ew));
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b1;
        act_out = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ld", 32'({ld_init, ld_reg}), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", 32'({found, all_zero, timeout}), 32'd0);
        chk("rst_winner", 32'(winner), 32'd0);
        chk("rst_iter", 32'(iter_cnt), 32'd0);
        rst = 1'b1;
        start = 1'b0;
        tick();

        // Immediate winner: neuron 1 = +5
        nv = 1;
        vecs[0] = {5'b00000, 5'b00000, 5'b00101, 5'b00000};
        do_run(0, 0);

        // Converging over three iterations, neuron 3 wins
        nv = 3;
        vecs[0] = {5'd6, 5'd5, 5'd4, 5'd3};
        vecs[1] = {5'd4, 5'd3, 5'd2, 5'd0};
        vecs[2] = {5'd7, 5'd0, 5'd0, 5'd0};
        do_run(0, 0);

        // All fields negative
        nv = 1;
        vecs[0] = {4{5'b10111}};
        do_run(0, 0);

        // Two constant positives: timeout at MAX_ITER
        nv = 1;
        vecs[0] = {5'b00000, 5'b01000, 5'b00000, 5'b01000};
        do_run(0, 0);

        // Reset during COMPUTE of the second iteration
        nv = 3;
        vecs[0] = {5'd6, 5'd5, 5'd4, 5'd3};
        vecs[1] = {5'd4, 5'd3, 5'd2, 5'd0};
        vecs[2] = {5'd0, 5'd0, 5'd9, 5'd0};
        act_out = vecs[0];
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        chk("mid_iter_pre", 32'(iter_cnt), 32'd1);
        rst = 1'b0;
        tick();
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ld_reg", 32'(ld_reg), 32'd0);
        chk("mid_iter", 32'(iter_cnt), 32'd0);
        chk("mid_found", 32'(found), 32'd0);
        rst = 1'b1;
        prev_w = 0;
        tick();
        do_run(0, 0);

        // Handshake: start toggling during busy, then held across back-to-back runs
        nv = 2;
        vecs[0] = {5'd1, 5'd0, 5'd2, 5'd0};
        vecs[1] = {5'd0, 5'd0, 5'd3, 5'd0};
        do_run(1, 1);
        nv = 1;
        vecs[0] = {4{5'b10000}};
        do_run(0, 1);
        nv = 1;
        vecs[0] = {5'd0, 5'd0, 5'd0, 5'd5};
        do_run(1, 0);

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            nv = int'($urandom_range(1, 6));
            for (int j = 0; j < nv; j++) begin
                logic [W-1:0] v;
                for (int i = 0; i < N; i++) v[5*i +: 5] = rnd_field();
                vecs[j] = v;
            end
            do_run(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxnet_ctrl.md
Name: maxnet_ctrl

Overview:
- Sequencing controller for the Maxnet neuron datapath: N neuron registers, a shared weighted-sum (MAC) network, and one 12-bit-to-5-bit activation unit per neuron. Each activation output is {sign, mag[3:0]} and clamps negatives to zero.
- Loads initial inputs, then iterates compute/update until exactly one neuron output stays positive, all outputs reach zero, or an iteration cap is hit.
- Reports winner index and status to the top-level FSM through a start/done handshake.

Parameters:
- N, 4, number of neurons; act_out carries N 5-bit fields.
- IDX_W, 2, width of winner index; must satisfy 2^IDX_W >= N.
- MAX_ITER, 15, maximum update iterations before timeout; 1..2^ITER_W-1.
- ITER_W, 4, width of iteration counter.
- SETTLE, 1, cycles the combinational MAC+activation path is given before update; >=1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  level request to begin a run; sampled only in IDLE.
- act_out  input  5*N  activation outputs; neuron i at [5i+4:5i], bit 5i+4 = sign.
- ld_init  output  1  one-cycle strobe: neuron regs load external inputs.
- ld_reg  output  1  one-cycle strobe: neuron regs load act_out.
- busy  output  1  high from LOAD through CHECK inclusive.
- done  output  1  one-cycle pulse on run completion.
- winner  output  IDX_W  index of the sole positive neuron; valid when found=1.
- found  output  1  run ended with exactly one positive neuron.
- all_zero  output  1  run ended with no positive neuron.
- timeout  output  1  run ended at MAX_ITER with more than one positive neuron.
- iter_cnt  output  ITER_W  completed update iterations in current or last run.

Behaviour:
- Reset: on a rising clk edge with rst=0, state goes to IDLE and all outputs go to 0, including winner, flags and iter_cnt. Reset wins over every other condition, including mid-run.
- Positive neuron i: sign bit = 0 AND mag != 0. A field with sign=1 is treated as non-positive regardless of mag.
- States and transitions:
  - IDLE: busy=0. start=1 goes to LOAD and clears found, all_zero, timeout and iter_cnt on that edge. The previous winner and flags hold until that edge.
  - LOAD: ld_init=1 for exactly this one cycle; next state COMPUTE with settle counter=0.
  - COMPUTE: waits SETTLE cycles; the counter increments each cycle; when count = SETTLE-1 the next state is UPDATE.
  - UPDATE: ld_reg=1 for exactly this one cycle. On the same edge: iter_cnt increments, and the controller registers pos_cnt (popcount of positive flags, saturating at 2) and pos_idx (lowest positive index). Next state CHECK.
  - CHECK, in priority order:
    - pos_cnt=1: found=1, winner=pos_idx, go to DONE.
    - pos_cnt=0: all_zero=1, winner=0, go to DONE.
    - iter_cnt=MAX_ITER: timeout=1, winner=0, go to DONE.
    - otherwise: go to COMPUTE with settle counter=0.
  - DONE: done=1 for this one cycle; next state IDLE unconditionally. A start still high in the following IDLE cycle launches a new run.
- Latency with SETTLE=1 and convergence on the first iteration: the start-sampling edge is followed by LOAD, COMPUTE, UPDATE, CHECK, DONE, so done is high in the 5th cycle after that edge.
- Each extra iteration adds SETTLE+2 cycles.
- Flags found, all_zero and timeout are mutually exclusive; exactly one is set after every completed run.
- ld_init and ld_reg are never high in the same cycle and never high outside LOAD and UPDATE.
- start is ignored while busy=1 or in DONE.
- iter_cnt never exceeds MAX_ITER and never wraps.
- All outputs are registered (Moore). No combinational path from act_out to any output.

Test Plan:
- Reset mid-run: assert rst=0 during COMPUTE of the 2nd iteration → next cycle busy=0, ld_reg=0, iter_cnt=0, found=0. A new start after release runs normally.
- Immediate winner: N=4, act_out fields {00000,00101,00000,00000} (neuron 1 = +5) held from start → ld_init high at cycle 1, ld_reg at cycle 3, done at cycle 5, found=1, winner=1, iter_cnt=1.
- Converging run: bench model returns fields with positives {3,4,5,6} on iteration 1, {2,3,4} on iteration 2, and only neuron 3 positive on iteration 3 → done with found=1, winner=3, iter_cnt=3, exactly 3 ld_reg pulses.
- All zero: act_out = 10111 in every field (negative, non-positive) → all_zero=1, found=0, winner=0, iter_cnt=1.
- Timeout: two fields constantly 01000 with MAX_ITER=15 → timeout=1, iter_cnt=15, exactly 15 ld_reg pulses, found=0.
- Handshake: start held high through the whole run and pulsed during busy → no restart while busy. A second run begins in the IDLE cycle after DONE, and flags clear on its start edge.
